// File: rtl/code_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package code_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    FAULT_PUSH,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } fifo_entry_t;

endpackage

// File: rtl/code_fetch_unit_fifo.sv
// Prefetch FIFO: power-of-two depth, single-cycle flush, occupancy count.
module fetch_fifo
  import code_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fifo_entry_t   entry_i,
  input  logic          pop_i,
  output fifo_entry_t   head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/code_fetch_unit.sv
// Fetch stage: owns the PC, issues code-RAM reads under a FIFO credit rule,
// buffers responses in a prefetch FIFO and handles redirects and fetch faults.
module code_fetch_unit
  import code_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned RAM_WORDS  = 40000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc,
  output logic              instr_fault
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [29:0]   WORDS_C = 30'(RAM_WORDS);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, pend_pc_q;
  logic          pending_q;
  logic [CW-1:0] fifo_count;
  logic          in_range, has_credit, issue, fault_push, push, pop;
  fifo_entry_t   push_entry, head;

  assign in_range   = (fetch_pc_q[31:2] < WORDS_C);
  assign has_credit = (({1'b0, fifo_count} + {{CW{1'b0}}, pending_q}) < {1'b0, DEPTH_C});
  assign pop        = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (redirect_pc[1:0] != 2'b00) ? FAULT_PUSH : RUN;
    end else begin
      case (state_q)
        RUN:        if (!in_range) state_d = FAULT_PUSH;
        FAULT_PUSH: if (fault_push) state_d = HALT;
        HALT:       state_d = HALT;
        default:    state_d = HALT;
      endcase
    end
  end

  // Issue is gated by reset_n so the RAM stays deselected while held in reset.
  always_comb begin
    issue      = reset_n && (state_q == RUN) && in_range && has_credit && !redirect_valid;
    fault_push = (state_q == FAULT_PUSH) && !pending_q && (fifo_count < DEPTH_C) && !redirect_valid;
    push       = fault_push || (pending_q && !redirect_valid);
    push_entry = fault_push ? '{data: NOP_INSTR, pc: fetch_pc_q, fault: 1'b1}
                            : '{data: ram_readdata, pc: pend_pc_q, fault: 1'b0};
    ram_clken      = issue;
    ram_chipselect = issue;
    ram_address    = issue ? fetch_pc_q[ADDR_W+1:2] : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (issue)     fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= issue;
      if (issue) pend_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .flush_i  (redirect_valid),
    .push_i   (push),
    .entry_i  (push_entry),
    .pop_i    (pop),
    .head_o   (head),
    .valid_o  (instr_valid),
    .count_o  (fifo_count)
  );

  assign instr_data  = head.data;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;

endmodule

// File: tb/tb_code_fetch_unit.sv
// Self-checking bench for code_fetch_unit against a stream-level model of the fetch sequence.
module tb_code_fetch_unit;

  localparam int unsigned RAM_WORDS = 40000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ram_address;
  logic        ram_chipselect, ram_clken;
  logic [31:0] ram_readdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data, instr_pc;
  logic        instr_fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pop_pc, m_iss_pc;
  bit          m_done;
  int          faults_seen;
  logic        last_clken, last_valid;
  logic [15:0] ram_addr_q = '0;

  always #5 clk = ~clk;

  // Code RAM model: registered address, word i holds i.
  always_ff @(posedge clk) if (ram_clken) ram_addr_q <= ram_address;
  assign ram_readdata = {16'h0000, ram_addr_q};

  code_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (4),
    .ADDR_W     (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p[31:2] >= 30'(RAM_WORDS));
  endfunction

  task automatic model_restart(input logic [31:0] target);
    m_pop_pc = target;
    m_iss_pc = target;
    m_done   = 1'b0;
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        pop, iss;
    logic [31:0] exp_d;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (m_done) begin
      check("valid_when_halted", 32'(instr_valid), 32'd0);
    end else if (instr_valid) begin
      exp_d = is_fault(m_pop_pc) ? 32'h0000_0013 : {16'h0000, m_pop_pc[17:2]};
      check("head_pc", instr_pc, m_pop_pc);
      check("head_data", instr_data, exp_d);
      check("head_fault", 32'(instr_fault), 32'(is_fault(m_pop_pc)));
    end else begin
      check("empty_data", instr_data, 32'd0);
      check("empty_pc", instr_pc, 32'd0);
      check("empty_fault", 32'(instr_fault), 32'd0);
    end
    if (ram_clken) begin
      check("issue_allowed", 32'(is_fault(m_iss_pc)), 32'd0);
      check("issue_addr", 32'(ram_address), 32'(m_iss_pc[17:2]));
    end
    check("cs_eq_clken", 32'(ram_chipselect), 32'(ram_clken));
    pop        = instr_valid & rdy;
    iss        = ram_clken;
    last_clken = iss;
    last_valid = instr_valid;
    @(posedge clk);
    if (pop && !m_done) begin
      if (is_fault(m_pop_pc)) begin
        m_done = 1'b1;
        faults_seen++;
      end else begin
        m_pop_pc += 32'd4;
      end
    end
    if (iss) m_iss_pc += 32'd4;
    if (rv) model_restart(rpc);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_cs"}, 32'(ram_chipselect), 32'd0);
    check({tag, "_clken"}, 32'(ram_clken), 32'd0);
    check({tag, "_addr"}, 32'(ram_address), 32'd0);
    check({tag, "_data"}, instr_data, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    int          cnt, f0;
    logic [31:0] tgt;
    logic [31:0] targets [8];
    model_restart(32'h0);
    faults_seen = 0;

    // Reset state, then release and stream from RESET_PC.
    @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (i == 0) check("first_issue", 32'(last_clken), 32'd1);
      if (i < 2)  check("valid_latency_low", 32'(last_valid), 32'd0);
      else        check("valid_throughput", 32'(last_valid), 32'd1);
    end

    // Decode stall: credit limits outstanding issues to the FIFO depth.
    cycle(1'b1, 1'b1, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (last_clken) cnt++;
    end
    check("stall_issue_count", 32'(cnt), 32'd4);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with three buffered entries and one response in flight.
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    check("redirect_had_entries", 32'(last_valid), 32'd1);
    cycle(1'b1, 1'b0, 32'h0);
    check("flushed_after_redirect", 32'(last_valid), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect: one fault entry, then halt.
    f0 = faults_seen;
    cycle(1'b1, 1'b1, 32'h102);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (last_clken) cnt++;
    end
    check("misalign_no_issue", 32'(cnt), 32'd0);
    check("misalign_fault_seen", 32'(faults_seen - f0), 32'd1);

    // End of RAM: last words delivered, then a range fault.
    f0 = faults_seen;
    cycle(1'b1, 1'b1, 32'h0002_70F0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (last_clken) cnt++;
    end
    check("range_issue_count", 32'(cnt), 32'd4);
    check("range_fault_seen", 32'(faults_seen - f0), 32'd1);

    // Asynchronous reset with a read in flight.
    cycle(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("pre_reset_issue", 32'(last_clken), 32'd1);
    reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_restart(32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // Randomised traffic: variable back-pressure and assorted redirect targets.
    targets[0] = 32'h0000_0000;
    targets[1] = 32'h0000_0040;
    targets[2] = 32'h0000_0102;
    targets[3] = 32'h0002_70F8;
    targets[4] = 32'h0003_0000;
    targets[5] = 32'hFFFF_FFFC;
    targets[6] = 32'h0000_1000;
    targets[7] = 32'h0000_0201;
    for (int i = 0; i < 400; i++) begin
      tgt = targets[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) tgt = 32'($urandom_range(0, 2000)) * 32'd4;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/code_fetch_unit.md
Name: code_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the code RAM (single-port on-chip RAM: 32-bit words, 16-bit word address, registered address, unregistered data).
- Owns the fetch PC and issues word reads to the RAM.
- Captures the returned words into a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing, and flags out-of-range or misaligned fetch targets.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- RAM_WORDS, 40000, number of valid 32-bit words in the code RAM.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- ADDR_W, 16, RAM word-address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ram_address  out  ADDR_W  word address to code RAM (pc[ADDR_W+1:2]).
- ram_chipselect  out  1  RAM select; high whenever a read is issued.
- ram_clken  out  1  RAM clock enable; high only in issue cycles so readdata holds otherwise.
- ram_readdata  in  32  RAM read data.
- redirect_valid  in  1  single-cycle redirect request.
- redirect_pc  in  32  byte target of redirect.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head.
- instr_data  out  32  instruction word.
- instr_pc  out  32  byte PC of instr_data.
- instr_fault  out  1  head entry is a fetch fault (instr_data = NOP 32'h0000_0013).

Behaviour:
- Reset (async, reset_n low):
  - instr_valid=0, ram_chipselect=0, ram_clken=0, ram_address=0.
  - FIFO empty, pending=0, fetch_pc=RESET_PC, state=RUN.
  - The first issue occurs on the first rising edge with reset_n high, subject to the RUN rules below.
- States: RUN, FAULT_PUSH, HALT.
- RUN, issue condition: fifo_count + pending < FIFO_DEPTH and no redirect this cycle.
  - Issue cycle t: ram_address=fetch_pc[17:2], ram_chipselect=ram_clken=1.
  - At edge t: pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- Response: ram_readdata is valid during cycle t+1 (one-cycle latency).
  - Pushed with pend_pc at the edge ending t+1, unless squashed.
  - Back-to-back issue allowed, giving 1 instruction/cycle sustained throughput.
- Range check before issue: if fetch_pc[31:2] >= RAM_WORDS, do not issue; go to FAULT_PUSH.
- FAULT_PUSH: wait for a free FIFO slot and no pending response, push {NOP, fetch_pc, fault=1}, then go to HALT.
- HALT: no issues; only a redirect leaves it.
- Redirect (any state, highest priority):
  - At the edge: FIFO cleared, an in-flight response is squashed (not pushed), fetch_pc<=redirect_pc.
  - If redirect_pc[1:0]!=0, go to FAULT_PUSH; otherwise go to RUN.
  - No issue in the redirect cycle; first new issue in the next cycle.
  - redirect_pc bits above the RAM range are caught by the range check.
- Output handshake: a pop occurs when instr_valid & instr_ready.
  - A pop in the same cycle as a redirect counts as consumed; the flush still clears the rest.
  - Push and pop in the same cycle keep the count unchanged; full with a simultaneous pop accepts the push.
- instr_* are driven from the FIFO head registers.
  - They stay stable while instr_valid & !instr_ready.
  - They are zero when the FIFO is empty.
- The credit rule guarantees a response never finds the FIFO full; no overflow path exists.
- PC arithmetic is 32-bit with wrap; a wrap past RAM_WORDS trips the range fault before any issue.

Decomposition:
- Package code_fetch_pkg: NOP_INSTR=32'h0000_0013, state enum {RUN, FAULT_PUSH, HALT}, FIFO entry struct {data[31:0], pc[31:0], fault}.
- Sub-module fetch_fifo: synchronous FIFO with parameterised depth, single-cycle flush, and count output.
- Issue/credit/state logic lives in code_fetch_unit.

Test Plan:
- Reset release, RAM preloaded word i = i, instr_ready=1 -> first ram_clken on cycle 1; instr_valid on cycle 3 with pc 0x0, then pc 0x4, 0x8… one per cycle, data 0,1,2.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (4) issues, then ram_clken low; readdata and instr_* held; on release, entries pcs 0x0–0xC in order, with no loss or duplication.
- redirect_valid with redirect_pc=0x100 while a read is pending and the FIFO holds 3 entries -> FIFO empty next cycle, squashed word never appears, next instr_pc=0x100.
- redirect_pc=0x102 -> single entry: fault=1, data 0x13, pc 0x102; no further ram_clken until the next redirect.
- redirect to byte (RAM_WORDS-1)*4 = 0x270FC -> word 39999 delivered, then a fault entry at pc 0x27100, then HALT.
- reset_n asserted mid-stream with pending=1 -> outputs zero immediately (async), restart at RESET_PC.
